// File: rtl/exe_stage.sv
// exe_stage: EXE pipeline stage. Holds one instruction from ID, computes
// its result with a single-cycle ALU or a 32-iteration restoring divider,
// issues the data-RAM request and forwards its pending write-back to ID.

`ifndef ID_TO_EXE_BUS_WD
`define ID_TO_EXE_BUS_WD 155
`endif
`ifndef EXE_TO_MEM_BUS_WD
`define EXE_TO_MEM_BUS_WD 75
`endif
`ifndef EXE_TO_ID_BUS_WD
`define EXE_TO_ID_BUS_WD 40
`endif

module exe_stage (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [`ID_TO_EXE_BUS_WD-1:0]  ID_to_EXE_bus,
    input  logic                          ID_to_EXE_valid,
    output logic                          EXE_allow_in,
    input  logic                          MEM_allow_in,
    output logic                          EXE_to_MEM_valid,
    output logic [`EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
    output logic                          data_ram_en,
    output logic [3:0]                    data_ram_we,
    output logic [31:0]                   data_ram_addr,
    output logic [31:0]                   data_ram_w_data,
    output logic [`EXE_TO_ID_BUS_WD-1:0]  EXE_to_ID_bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Pipeline state
    logic                         valid_q;
    logic [`ID_TO_EXE_BUS_WD-1:0] bus_q;
    logic                         ready_go_s;

    // Divider state
    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;

    // Decoded fields of the latched instruction
    logic [11:0] alu_op_s;
    logic [3:0]  div_op_s;
    logic        ld_en_s, st_en_s, ld_signed_s, rf_w_en_s;
    logic [1:0]  mem_size_s;
    logic [4:0]  waddr_s;
    logic [31:0] src1_s, src2_s, st_data_s, pc_s;

    assign alu_op_s    = bus_q[154:143];
    assign div_op_s    = bus_q[142:139];
    assign ld_en_s     = bus_q[138];
    assign st_en_s     = bus_q[137];
    assign mem_size_s  = bus_q[136:135];
    assign ld_signed_s = bus_q[134];
    assign rf_w_en_s   = bus_q[133];
    assign waddr_s     = bus_q[132:128];
    assign src1_s      = bus_q[127:96];
    assign src2_s      = bus_q[95:64];
    assign st_data_s   = bus_q[63:32];
    assign pc_s        = bus_q[31:0];

    logic is_div_s;
    assign is_div_s = |div_op_s;

    // Handshake
    assign ready_go_s       = ~is_div_s | (state_q == S_DONE);
    assign EXE_allow_in     = ~valid_q | (MEM_allow_in & ready_go_s);
    assign EXE_to_MEM_valid = valid_q & ready_go_s;

    // Stage valid flag: refilled from ID whenever the stage can accept
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (EXE_allow_in) begin
            valid_q <= ID_to_EXE_valid;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Instruction register: captures a new instruction only on a real transfer
    always_ff @(posedge clk) begin
        if (ID_to_EXE_valid & EXE_allow_in) begin
            bus_q <= ID_to_EXE_bus;
        end else begin
            bus_q <= bus_q;
        end
    end

    // Single-cycle ALU; one-hot select, all-zero select yields zero
    logic [31:0] alu_res_s;
    logic [4:0]  shamt_s;
    assign shamt_s = src2_s[4:0];
    always_comb begin
        alu_res_s = 32'd0;
        if (alu_op_s[0])  alu_res_s = alu_res_s | (src1_s + src2_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[1])  alu_res_s = alu_res_s | (src1_s - src2_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[2])  alu_res_s = alu_res_s | {31'd0, ($signed(src1_s) < $signed(src2_s))};
        else              alu_res_s = alu_res_s;
        if (alu_op_s[3])  alu_res_s = alu_res_s | {31'd0, (src1_s < src2_s)};
        else              alu_res_s = alu_res_s;
        if (alu_op_s[4])  alu_res_s = alu_res_s | (src1_s & src2_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[5])  alu_res_s = alu_res_s | ~(src1_s | src2_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[6])  alu_res_s = alu_res_s | (src1_s | src2_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[7])  alu_res_s = alu_res_s | (src1_s ^ src2_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[8])  alu_res_s = alu_res_s | (src1_s << shamt_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[9])  alu_res_s = alu_res_s | (src1_s >> shamt_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[10]) alu_res_s = alu_res_s | 32'($signed(src1_s) >>> shamt_s);
        else              alu_res_s = alu_res_s;
        if (alu_op_s[11]) alu_res_s = alu_res_s | src2_s;
        else              alu_res_s = alu_res_s;
    end

    // Divider operand preparation: signed ops divide magnitudes
    logic        div_signed_s, want_rem_s;
    logic [31:0] abs1_s, abs2_s;
    assign div_signed_s = div_op_s[0] | div_op_s[1];
    assign want_rem_s   = div_op_s[1] | div_op_s[3];
    assign abs1_s = (div_signed_s & src1_s[31]) ? (32'd0 - src1_s) : src1_s;
    assign abs2_s = (div_signed_s & src2_s[31]) ? (32'd0 - src2_s) : src2_s;

    // One restoring step: shift in next dividend bit, subtract if it fits
    logic [32:0] rem_sh_s, diff_s;
    logic [31:0] rem_step_s, quot_step_s;
    always_comb begin
        rem_sh_s = {rem_q, quot_q[31]};
        diff_s   = rem_sh_s - {1'b0, dvsr_q};
        if (!diff_s[32]) begin
            rem_step_s  = diff_s[31:0];
            quot_step_s = {quot_q[30:0], 1'b1};
        end else begin
            rem_step_s  = rem_sh_s[31:0];
            quot_step_s = {quot_q[30:0], 1'b0};
        end
    end

    // Divider next-state: IDLE -> RUN (32 steps) -> DONE -> IDLE on handoff
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (valid_q & is_div_s) state_d = S_RUN;
                else                    state_d = S_IDLE;
            end
            S_RUN: begin
                if (cnt_q == 6'd31) state_d = S_DONE;
                else                state_d = S_RUN;
            end
            S_DONE: begin
                if (EXE_to_MEM_valid & MEM_allow_in) state_d = S_IDLE;
                else                                  state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divider datapath registers and FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (valid_q & is_div_s) begin
                        cnt_q  <= 6'd0;
                        quot_q <= abs1_s;
                        rem_q  <= 32'd0;
                        dvsr_q <= abs2_s;
                    end else begin
                        cnt_q  <= cnt_q;
                    end
                end
                S_RUN: begin
                    cnt_q  <= cnt_q + 6'd1;
                    quot_q <= quot_step_s;
                    rem_q  <= rem_step_s;
                end
                S_DONE:  cnt_q <= cnt_q;
                default: cnt_q <= 6'd0;
            endcase
        end
    end

    // Sign fix-up and the divide-by-zero / overflow corner cases
    logic [31:0] quot_fix_s, rem_fix_s, div_res_s;
    always_comb begin
        if (div_signed_s & (src1_s[31] ^ src2_s[31])) quot_fix_s = 32'd0 - quot_q;
        else                                           quot_fix_s = quot_q;
        if (div_signed_s & src1_s[31]) rem_fix_s = 32'd0 - rem_q;
        else                           rem_fix_s = rem_q;
        if (src2_s == 32'd0) begin
            quot_fix_s = 32'hFFFF_FFFF;
            rem_fix_s  = src1_s;
        end else begin
            quot_fix_s = quot_fix_s;
            rem_fix_s  = rem_fix_s;
        end
        div_res_s = want_rem_s ? rem_fix_s : quot_fix_s;
    end

    logic [31:0] result_s;
    assign result_s = is_div_s ? div_res_s : alu_res_s;

    assign EXE_to_MEM_bus = {rf_w_en_s, ld_en_s, ld_signed_s, mem_size_s, ld_en_s,
                             waddr_s, result_s, pc_s};

    // Data-RAM request: strobes follow access size and low address bits
    always_comb begin
        data_ram_en     = valid_q & ready_go_s & MEM_allow_in & (ld_en_s | st_en_s);
        data_ram_addr   = result_s;
        data_ram_we     = 4'b0000;
        data_ram_w_data = st_data_s;
        case (mem_size_s)
            2'b01: data_ram_w_data = {4{st_data_s[7:0]}};
            2'b10: data_ram_w_data = {2{st_data_s[15:0]}};
            default: data_ram_w_data = st_data_s;
        endcase
        if (data_ram_en & st_en_s) begin
            case (mem_size_s)
                2'b00:   data_ram_we = 4'b1111;
                2'b01:   data_ram_we = 4'b0001 << result_s[1:0];
                2'b10:   data_ram_we = 4'b0011 << {result_s[1], 1'b0};
                default: data_ram_we = 4'b0000;
            endcase
        end else begin
            data_ram_we = 4'b0000;
        end
    end

    assign EXE_to_ID_bus = {valid_q & rf_w_en_s, waddr_s, ld_en_s,
                            ready_go_s & ~ld_en_s, result_s};

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized scoreboard bench for exe_stage. The driver pushes
// the expected response of each instruction it presents; an independent
// monitor tracks stage occupancy and checks every output cycle by cycle.
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic [154:0] ID_to_EXE_bus;
    logic         ID_to_EXE_valid;
    logic         EXE_allow_in;
    logic         MEM_allow_in;
    logic         EXE_to_MEM_valid;
    logic [74:0]  EXE_to_MEM_bus;
    logic         data_ram_en;
    logic [3:0]   data_ram_we;
    logic [31:0]  data_ram_addr;
    logic [31:0]  data_ram_w_data;
    logic [39:0]  EXE_to_ID_bus;

    exe_stage dut (
        .clk(clk), .reset(reset),
        .ID_to_EXE_bus(ID_to_EXE_bus), .ID_to_EXE_valid(ID_to_EXE_valid),
        .EXE_allow_in(EXE_allow_in), .MEM_allow_in(MEM_allow_in),
        .EXE_to_MEM_valid(EXE_to_MEM_valid), .EXE_to_MEM_bus(EXE_to_MEM_bus),
        .data_ram_en(data_ram_en), .data_ram_we(data_ram_we),
        .data_ram_addr(data_ram_addr), .data_ram_w_data(data_ram_w_data),
        .EXE_to_ID_bus(EXE_to_ID_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [74:0] bus;
        bit          is_div, ld, st, rfw;
        logic [4:0]  waddr;
        logic [31:0] res;
        logic [3:0]  we;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   occ;
    int   cyc;
    bit   mon_en;
    int   mem_mode;
    int   checks;
    int   failures;

    task automatic chk(input string nm, input logic [74:0] act, input logic [74:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference result straight from the instruction semantics
    function automatic logic [31:0] ref_result(input logic [11:0] aop, input logic [3:0] dop,
                                               input logic [31:0] a, input logic [31:0] b);
        int sa, sbv;
        sa = a; sbv = b;
        if (dop != 4'd0) begin
            if (b == 32'd0) return (dop[1] | dop[3]) ? a : 32'hFFFF_FFFF;
            if (dop[0] | dop[1]) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return dop[1] ? 32'd0 : 32'h8000_0000;
                return dop[1] ? 32'(sa % sbv) : 32'(sa / sbv);
            end
            return dop[3] ? a % b : a / b;
        end
        case (aop)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return (sa < sbv) ? 32'd1 : 32'd0;
            12'h008: return (a < b) ? 32'd1 : 32'd0;
            12'h010: return a & b;
            12'h020: return ~(a | b);
            12'h040: return a | b;
            12'h080: return a ^ b;
            12'h100: return a << b[4:0];
            12'h200: return a >> b[4:0];
            12'h400: return 32'(sa >>> b[4:0]);
            12'h800: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Present one instruction, push its expectation, hold until accepted
    task automatic issue(input logic [11:0] aop, input logic [3:0] dop, input bit ld,
                         input bit st, input logic [1:0] msz, input bit lds, input bit rfw,
                         input logic [4:0] wa, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic [31:0] pc);
        exp_t e;
        bit   acc;
        e.is_div = (dop != 4'd0);
        e.ld = ld; e.st = st; e.rfw = rfw; e.waddr = wa;
        e.res = ref_result(aop, dop, a, b);
        e.bus = {rfw, ld, lds, msz, ld, wa, e.res, pc};
        case (msz)
            2'b00: begin e.we = 4'b1111; e.wdata = sd; end
            2'b01: begin e.we = 4'b0001 << e.res[1:0]; e.wdata = {4{sd[7:0]}}; end
            2'b10: begin e.we = e.res[1] ? 4'b1100 : 4'b0011; e.wdata = {2{sd[15:0]}}; end
            default: begin e.we = 4'b0000; e.wdata = sd; end
        endcase
        sb.push_back(e);
        ID_to_EXE_bus   = {aop, dop, ld, st, msz, lds, rfw, wa, a, b, sd, pc};
        ID_to_EXE_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (EXE_allow_in) begin acc = 1'b1; break; end
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout: got allow_in=0 for 300 cycles expected acceptance");
        end
        @(posedge clk); #1;
        ID_to_EXE_valid = 1'b0;
    endtask

    // MEM back-pressure generator
    initial begin
        MEM_allow_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mem_mode)
                1:       MEM_allow_in = ($urandom_range(0, 3) != 0);
                2:       MEM_allow_in = 1'b0;
                default: MEM_allow_in = 1'b1;
            endcase
        end
    end

    // Monitor: per-cycle checks against the occupancy model, then advance it
    initial begin
        bit exp_ready, exp_valid, exp_allow, exp_en;
        wait (mon_en);
        forever begin
            @(negedge clk);
            exp_ready = occ && (!cur.is_div || cyc >= 33);
            exp_valid = occ && exp_ready;
            exp_allow = !occ || (MEM_allow_in && exp_ready);
            exp_en    = exp_valid && MEM_allow_in && (cur.ld || cur.st);
            chk("to_mem_valid", EXE_to_MEM_valid, exp_valid);
            chk("allow_in", EXE_allow_in, exp_allow);
            chk("ram_en", data_ram_en, exp_en);
            chk("ram_we", data_ram_we, (exp_en && cur.st) ? cur.we : 4'b0000);
            if (exp_en) chk("ram_addr", data_ram_addr, cur.res);
            if (exp_en && cur.st) chk("ram_wdata", data_ram_w_data, cur.wdata);
            if (exp_valid) chk("mem_bus", EXE_to_MEM_bus, cur.bus);
            chk("fwd_w_en", EXE_to_ID_bus[39], occ && cur.rfw);
            if (occ) begin
                chk("fwd_addr", EXE_to_ID_bus[38:34], cur.waddr);
                chk("fwd_is_load", EXE_to_ID_bus[33], cur.ld);
                chk("fwd_ready", EXE_to_ID_bus[32], exp_ready && !cur.ld);
                if (exp_ready) chk("fwd_data", EXE_to_ID_bus[31:0], cur.res);
            end
            if (reset) begin
                occ = 1'b0; cyc = 0; sb.delete();
            end else if (exp_allow) begin
                if (ID_to_EXE_valid) begin
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL scoreboard_empty: got accept expected none");
                    end else begin
                        cur = sb.pop_front();
                    end
                    occ = 1'b1; cyc = 0;
                end else begin
                    occ = 1'b0;
                end
            end else begin
                cyc++;
            end
        end
    end

    // Main sequence: reset, directed cases, randomized traffic, drain
    initial begin
        logic [11:0] aop;
        logic [3:0]  dop;
        bit          ld, st, lds, rfw;
        logic [1:0]  msz;
        logic [31:0] a, b;
        int          kind, sel;
        bit          drained;
        checks = 0; failures = 0; occ = 1'b0; cyc = 0; mon_en = 1'b0; mem_mode = 0;
        reset = 1'b1; ID_to_EXE_valid = 1'b0; ID_to_EXE_bus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_to_mem_valid", EXE_to_MEM_valid, 1'b0);
        chk("rst_allow_in", EXE_allow_in, 1'b1);
        chk("rst_ram_en", data_ram_en, 1'b0);
        chk("rst_ram_we", data_ram_we, 4'b0000);
        chk("rst_fwd_w_en", EXE_to_ID_bus[39], 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // add overflow wrap
        issue(12'h001, 4'h0, 0, 0, 2'b00, 0, 1, 5'd3, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h100);
        // st.b to 0x1003 with 3 cycles of MEM back-pressure, then release
        mem_mode = 2;
        issue(12'h001, 4'h0, 0, 1, 2'b01, 0, 0, 5'd0, 32'h1000, 32'd3, 32'h0000_00AB, 32'h104);
        repeat (3) @(posedge clk);
        #1 mem_mode = 0;
        // divider corner cases
        issue(12'h000, 4'b0001, 0, 0, 2'b00, 0, 1, 5'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h108);
        issue(12'h000, 4'b0010, 0, 0, 2'b00, 0, 1, 5'd5, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h10C);
        issue(12'h000, 4'b0100, 0, 0, 2'b00, 0, 1, 5'd6, 32'd100, 32'd0, 32'd0, 32'h110);
        issue(12'h000, 4'b1000, 0, 0, 2'b00, 0, 1, 5'd7, 32'd100, 32'd0, 32'd0, 32'h114);
        issue(12'h000, 4'b0001, 0, 0, 2'b00, 0, 1, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h118);
        // ld.h at address 6
        issue(12'h001, 4'h0, 1, 0, 2'b10, 0, 1, 5'd9, 32'd2, 32'd4, 32'd0, 32'h11C);
        // reset in the middle of a divide, then an add
        issue(12'h000, 4'b0100, 0, 0, 2'b00, 0, 1, 5'd10, 32'd1000, 32'd7, 32'd0, 32'h120);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(12'h001, 4'h0, 0, 0, 2'b00, 0, 1, 5'd11, 32'd5, 32'd6, 32'd0, 32'h124);

        // randomized traffic with random back-pressure
        mem_mode = 1;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            aop  = 12'h001 << $urandom_range(0, 11);
            if ($urandom_range(0, 15) == 0) aop = 12'h000;
            dop = 4'h0; ld = 0; st = 0;
            msz = 2'($urandom_range(0, 2));
            lds = 1'($urandom_range(0, 1));
            rfw = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            if (kind <= 2) begin
                dop = 4'b0001 << $urandom_range(0, 3);
                sel = $urandom_range(0, 5);
                if (sel == 0) b = 32'd0;
                else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                else if (sel == 2) b = $urandom_range(1, 20);
                else if (sel == 3) b = 32'd0 - $urandom_range(1, 20);
            end else if (kind <= 4) begin
                ld = 1; rfw = 1; aop = 12'h001;
            end else if (kind == 5) begin
                st = 1; rfw = 0; aop = 12'h001;
            end
            issue(aop, dop, ld, st, msz, lds, rfw, 5'($urandom_range(0, 31)), a, b,
                  $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        mem_mode = 0;
        drained = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (sb.size() == 0 && !occ) begin drained = 1'b1; break; end
        end
        checks++;
        if (!drained) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size() + int'(occ));
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
